// File: rtl/fta_bridge32to256.sv
// 32-bit to 256-bit FTA upsizing bridge: one outstanding request, lane
// steering of select/data, tid-matched response, watchdog error completion.
package fta_bridge32to256_pkg;

    typedef struct packed {
        logic        cyc;
        logic        stb;
        logic        we;
        logic [4:0]  cmd;
        logic [1:0]  bte;
        logic [2:0]  cti;
        logic [7:0]  tid;
        logic [31:0] padr;
        logic [3:0]  sel;
        logic [31:0] dat;
    } fta_cmd_request32_t;

    typedef struct packed {
        logic         cyc;
        logic         stb;
        logic         we;
        logic [4:0]   cmd;
        logic [1:0]   bte;
        logic [2:0]   cti;
        logic [7:0]   tid;
        logic [31:0]  padr;
        logic [31:0]  sel;
        logic [255:0] data1;
    } fta_cmd_request256_t;

    typedef struct packed {
        logic        ack;
        logic        err;
        logic        rty;
        logic        stall;
        logic        next;
        logic [7:0]  tid;
        logic [3:0]  pri;
        logic [31:0] adr;
        logic [31:0] dat;
    } fta_cmd_response32_t;

    typedef struct packed {
        logic         ack;
        logic         err;
        logic         rty;
        logic         stall;
        logic         next;
        logic [7:0]   tid;
        logic [3:0]   pri;
        logic [31:0]  adr;
        logic [255:0] dat;
    } fta_cmd_response256_t;

endpackage

module fta_bridge32to256
    import fta_bridge32to256_pkg::*;
#(
    parameter int TIMEOUT = 1023
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  fta_cmd_request32_t   s_req,
    output fta_cmd_response32_t  s_resp,
    output fta_cmd_request256_t  m_req,
    input  fta_cmd_response256_t m_resp
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        RESP
    } state_t;

    localparam logic [15:0] TMO = TIMEOUT[15:0];

    state_t              state;
    logic [15:0]         cnt;
    logic [2:0]          lane;
    fta_cmd_response32_t resp_q;
    logic                any_resp;
    logic                hit;
    logic                unused_ok;

    function automatic fta_cmd_request256_t idle_req();
        fta_cmd_request256_t r;
        r      = '0;
        r.padr = 32'hFFFF_FFFF;
        return r;
    endfunction

    assign unused_ok = m_resp.next;
    assign any_resp  = m_resp.ack | m_resp.err | m_resp.rty;

    // m_req.tid holds the captured tid for the whole REQ/WAIT window
    assign hit = any_resp && (m_resp.tid == m_req.tid) &&
                 ((state == WAIT) || ((state == REQ) && !m_resp.stall));

    always_comb begin
        s_resp       = resp_q;
        s_resp.stall = (state != IDLE);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state  <= IDLE;
            m_req  <= idle_req();
            resp_q <= '0;
            cnt    <= '0;
            lane   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    resp_q <= '0;
                    if (s_req.cyc && s_req.stb) begin
                        state       <= REQ;
                        cnt         <= '0;
                        lane        <= s_req.padr[4:2];
                        m_req.cyc   <= 1'b1;
                        m_req.stb   <= 1'b1;
                        m_req.we    <= s_req.we;
                        m_req.cmd   <= s_req.cmd;
                        m_req.bte   <= s_req.bte;
                        m_req.cti   <= s_req.cti;
                        m_req.tid   <= s_req.tid;
                        m_req.padr  <= s_req.padr;
                        m_req.sel   <= {28'h0, s_req.sel} << {s_req.padr[4:2], 2'b00};
                        m_req.data1 <= {8{s_req.dat}};
                    end
                end
                REQ, WAIT: begin
                    if ((state == REQ) && !m_resp.stall) begin
                        state     <= WAIT;
                        m_req.stb <= 1'b0;
                    end
                    // a real response beats a simultaneous timeout
                    if (hit) begin
                        state       <= RESP;
                        m_req       <= idle_req();
                        resp_q.ack  <= m_resp.ack;
                        resp_q.err  <= m_resp.err;
                        resp_q.rty  <= m_resp.rty;
                        resp_q.tid  <= m_resp.tid;
                        resp_q.adr  <= m_resp.adr;
                        resp_q.pri  <= m_resp.pri;
                        resp_q.next <= 1'b0;
                        resp_q.dat  <= m_resp.dat[{lane, 5'b0} +: 32];
                    end else if (cnt == TMO) begin
                        state      <= RESP;
                        m_req      <= idle_req();
                        resp_q     <= '0;
                        resp_q.err <= 1'b1;
                        resp_q.tid <= m_req.tid;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                RESP: begin
                    state  <= IDLE;
                    resp_q <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fta_bridge32to256.sv
// Self-checking bench for fta_bridge32to256: directed scenarios plus
// randomized transactions checked against a lane/word level reference model.
module tb_fta_bridge32to256;
    import fta_bridge32to256_pkg::*;

    localparam int TMO = 8;

    logic                 clk;
    logic                 rst_i;
    fta_cmd_request32_t   s_req;
    fta_cmd_response32_t  s_resp;
    fta_cmd_request256_t  m_req;
    fta_cmd_response256_t m_resp;

    int checks;
    int failures;

    fta_bridge32to256 #(.TIMEOUT(TMO)) dut (
        .clk_i  (clk),
        .rst_i  (rst_i),
        .s_req  (s_req),
        .s_resp (s_resp),
        .m_req  (m_req),
        .m_resp (m_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // model: byte select bit i lands at byte (lane*4 + i) of the wide word
    function automatic logic [31:0] exp_sel(logic [3:0] sel, logic [31:0] padr);
        int base;
        logic [31:0] r;
        base = 4 * int'(padr[4:2]);
        r = '0;
        for (int i = 0; i < 4; i++)
            if (sel[i]) r[base + i] = 1'b1;
        return r;
    endfunction

    function automatic logic [255:0] exp_data(logic [31:0] d);
        logic [255:0] r;
        r = '0;
        for (int k = 0; k < 8; k++) r = (r << 32) | 256'(d);
        return r;
    endfunction

    function automatic logic [255:0] pack_words(logic [31:0] w [8]);
        logic [255:0] r;
        r = '0;
        for (int k = 7; k >= 0; k--) r = (r << 32) | 256'(w[k]);
        return r;
    endfunction

    // Drives one transaction; edge 0 is the edge that samples the request.
    task automatic run_txn(
        input  fta_cmd_request32_t  rq,
        input  int                  stall_n,
        input  int                  r_edge,
        input  logic [2:0]          r_kind,
        input  logic [255:0]        wide,
        input  int                  bad_edge,
        output fta_cmd_request256_t mq0,
        output fta_cmd_request256_t mq_resp,
        output fta_cmd_response32_t sr,
        output int                  first_e,
        output int                  n_resp,
        output int                  stb_n,
        output bit                  stable,
        output bit                  stall_ok,
        output bit                  wait_ok
    );
        s_req     = rq;
        s_req.cyc = 1'b1;
        s_req.stb = 1'b1;
        first_e = -1;
        n_resp = 0;
        stb_n = 0;
        stable = 1'b1;
        stall_ok = 1'b1;
        wait_ok = 1'b1;
        mq0 = '0;
        mq_resp = '0;
        sr = '0;
        for (int e = 0; e <= 16; e++) begin
            m_resp = '0;
            m_resp.stall = (e >= 1) && (e <= stall_n);
            if (e == bad_edge) begin
                m_resp.ack = 1'b1;
                m_resp.tid = rq.tid ^ 8'h03;
                m_resp.dat = ~wide;
            end
            if (e == r_edge) begin
                {m_resp.ack, m_resp.err, m_resp.rty} = r_kind;
                m_resp.tid = rq.tid;
                m_resp.dat = wide;
                m_resp.adr = rq.padr ^ 32'h5A5A_0000;
                m_resp.pri = rq.tid[3:0];
            end
            @(posedge clk);
            @(negedge clk);
            if (e == 0) mq0 = m_req;
            if (m_req.stb) begin
                stb_n++;
                if (m_req !== mq0) stable = 1'b0;
            end
            if (s_resp.ack | s_resp.err | s_resp.rty) begin
                n_resp++;
                if (first_e < 0) begin
                    first_e = e;
                    sr = s_resp;
                    mq_resp = m_req;
                    s_req.cyc = 1'b0;
                    s_req.stb = 1'b0;
                end
            end
            if (first_e < 0 && !s_resp.stall) stall_ok = 1'b0;
            if (first_e < 0 && e > stall_n && (m_req.stb || !m_req.cyc))
                wait_ok = 1'b0;
        end
        m_resp = '0;
        s_req = '0;
    endtask

    task automatic test_reset;
        rst_i = 1'b0;
        s_req = '0;
        m_resp = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_i = 1'b1;
        checks++;
        if (s_resp !== '0) begin
            failures++;
            $display("FAIL reset_sresp got=%h exp=0", s_resp);
        end
        checks++;
        if (m_req.cyc !== 1'b0 || m_req.stb !== 1'b0 || m_req.padr !== 32'hFFFF_FFFF ||
            m_req.sel !== '0 || m_req.data1 !== '0) begin
            failures++;
            $display("FAIL reset_mreq got=%h padr=%h exp_padr=ffffffff", m_req.cyc, m_req.padr);
        end
    endtask

    task automatic test_read_lane5;
        fta_cmd_request32_t rq;
        fta_cmd_request256_t mq0, mqr;
        fta_cmd_response32_t sr;
        logic [31:0] w [8];
        int fe, nr, sn;
        bit st, sk, wk;
        for (int k = 0; k < 8; k++) w[k] = $urandom;
        w[5] = 32'hCAFE_BABE;
        rq = '0;
        rq.padr = 32'h0000_1014;
        rq.sel = 4'hF;
        rq.tid = 8'h21;
        run_txn(rq, 0, 1, 3'b100, pack_words(w), -1, mq0, mqr, sr, fe, nr, sn, st, sk, wk);
        checks++;
        if (mq0.sel !== 32'h00F0_0000 || mq0.padr !== 32'h0000_1014 || mq0.we !== 1'b0) begin
            failures++;
            $display("FAIL read_mreq sel=%h padr=%h exp=00f00000/00001014", mq0.sel, mq0.padr);
        end
        checks++;
        if (fe !== 1 || nr !== 1) begin
            failures++;
            $display("FAIL read_latency edge=%0d count=%0d exp=1/1", fe, nr);
        end
        checks++;
        if (sr.ack !== 1'b1 || sr.dat !== 32'hCAFE_BABE || sr.tid !== 8'h21) begin
            failures++;
            $display("FAIL read_sresp ack=%b dat=%h tid=%h exp=1/cafebabe/21", sr.ack, sr.dat, sr.tid);
        end
        checks++;
        if (!sk || sr.stall !== 1'b1) begin
            failures++;
            $display("FAIL read_stall got=%b exp=1", sk);
        end
        checks++;
        if (mqr.cyc !== 1'b0 || mqr.padr !== 32'hFFFF_FFFF) begin
            failures++;
            $display("FAIL read_idle cyc=%b padr=%h exp=0/ffffffff", mqr.cyc, mqr.padr);
        end
    endtask

    task automatic test_write_byte;
        fta_cmd_request32_t rq;
        fta_cmd_request256_t mq0, mqr;
        fta_cmd_response32_t sr;
        int fe, nr, sn;
        bit st, sk, wk;
        rq = '0;
        rq.padr = 32'h0000_0008;
        rq.sel = 4'b0100;
        rq.dat = 32'h1122_3344;
        rq.we = 1'b1;
        rq.tid = 8'h05;
        run_txn(rq, 0, 2, 3'b100, '0, -1, mq0, mqr, sr, fe, nr, sn, st, sk, wk);
        checks++;
        if (mq0.sel !== 32'h0000_0400 || mq0.we !== 1'b1) begin
            failures++;
            $display("FAIL write_sel got=%h we=%b exp=00000400/1", mq0.sel, mq0.we);
        end
        checks++;
        if (mq0.data1 !== {8{32'h1122_3344}}) begin
            failures++;
            $display("FAIL write_data got=%h exp=8x11223344", mq0.data1);
        end
        checks++;
        if (fe !== 2 || sr.ack !== 1'b1 || !wk) begin
            failures++;
            $display("FAIL write_ack edge=%0d ack=%b wait=%b exp=2/1/1", fe, sr.ack, wk);
        end
    endtask

    task automatic test_stall;
        fta_cmd_request32_t rq;
        fta_cmd_request256_t mq0, mqr;
        fta_cmd_response32_t sr;
        int fe, nr, sn;
        bit st, sk, wk;
        rq = '0;
        rq.padr = 32'h0000_2000 | $urandom_range(0, 31);
        rq.sel = 4'hF;
        rq.tid = 8'h33;
        run_txn(rq, 5, 7, 3'b100, '0, -1, mq0, mqr, sr, fe, nr, sn, st, sk, wk);
        checks++;
        if (sn !== 6 || !st) begin
            failures++;
            $display("FAIL stall_stb cycles=%0d stable=%b exp=6/1", sn, st);
        end
        checks++;
        if (fe !== 7 || nr !== 1 || sr.ack !== 1'b1 || !wk) begin
            failures++;
            $display("FAIL stall_resp edge=%0d count=%0d exp=7/1", fe, nr);
        end
    endtask

    task automatic test_tid_filter;
        fta_cmd_request32_t rq;
        fta_cmd_request256_t mq0, mqr;
        fta_cmd_response32_t sr;
        int fe, nr, sn;
        bit st, sk, wk;
        rq = '0;
        rq.padr = 32'h0000_0004;
        rq.sel = 4'hF;
        rq.tid = 8'h21;
        run_txn(rq, 0, 4, 3'b100, {8{32'h0BAD_F00D}}, 2, mq0, mqr, sr, fe, nr, sn, st, sk, wk);
        checks++;
        if (fe !== 4 || nr !== 1) begin
            failures++;
            $display("FAIL tid_filter edge=%0d count=%0d exp=4/1", fe, nr);
        end
        checks++;
        if (sr.tid !== 8'h21 || sr.dat !== 32'h0BAD_F00D) begin
            failures++;
            $display("FAIL tid_data tid=%h dat=%h exp=21/0badf00d", sr.tid, sr.dat);
        end
    endtask

    task automatic test_timeout;
        fta_cmd_request32_t rq;
        fta_cmd_request256_t mq0, mqr;
        fta_cmd_response32_t sr;
        int fe, nr, sn;
        bit st, sk, wk;
        rq = '0;
        rq.padr = 32'h0000_0010;
        rq.sel = 4'hF;
        rq.tid = 8'h44;
        run_txn(rq, 0, TMO + 4, 3'b100, {8{32'hFFFF_FFFF}}, -1,
                mq0, mqr, sr, fe, nr, sn, st, sk, wk);
        checks++;
        if (fe !== TMO + 1) begin
            failures++;
            $display("FAIL timeout_edge got=%0d exp=%0d", fe, TMO + 1);
        end
        checks++;
        if (sr.err !== 1'b1 || sr.ack !== 1'b0 || sr.rty !== 1'b0 ||
            sr.dat !== '0 || sr.tid !== 8'h44) begin
            failures++;
            $display("FAIL timeout_resp err=%b ack=%b dat=%h tid=%h exp=1/0/0/44",
                     sr.err, sr.ack, sr.dat, sr.tid);
        end
        checks++;
        if (nr !== 1) begin
            failures++;
            $display("FAIL timeout_late count=%0d exp=1", nr);
        end
    endtask

    task automatic test_reset_mid;
        fta_cmd_request32_t rq;
        fta_cmd_request256_t mq0, mqr;
        fta_cmd_response32_t sr;
        logic [31:0] w [8];
        int fe, nr, sn, seen;
        bit st, sk, wk;
        rq = '0;
        rq.cyc = 1'b1;
        rq.stb = 1'b1;
        rq.padr = 32'h0000_0018;
        rq.sel = 4'hF;
        rq.tid = 8'h55;
        s_req = rq;
        m_resp = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        s_req = '0;
        rst_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_i = 1'b1;
        checks++;
        if (m_req.cyc !== 1'b0 || m_req.padr !== 32'hFFFF_FFFF ||
            s_resp.stall !== 1'b0 || s_resp.ack !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid cyc=%b padr=%h stall=%b ack=%b exp=0/ffffffff/0/0",
                     m_req.cyc, m_req.padr, s_resp.stall, s_resp.ack);
        end
        seen = 0;
        m_resp.ack = 1'b1;
        m_resp.tid = 8'h55;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            m_resp = '0;
            if (s_resp.ack | s_resp.err | s_resp.rty) seen++;
        end
        checks++;
        if (seen !== 0) begin
            failures++;
            $display("FAIL reset_silent count=%0d exp=0", seen);
        end
        for (int k = 0; k < 8; k++) w[k] = $urandom;
        rq.tid = 8'h66;
        run_txn(rq, 1, 3, 3'b100, pack_words(w), -1, mq0, mqr, sr, fe, nr, sn, st, sk, wk);
        checks++;
        if (fe !== 3 || sr.ack !== 1'b1 || sr.dat !== w[6]) begin
            failures++;
            $display("FAIL reset_new edge=%0d dat=%h exp=3/%h", fe, sr.dat, w[6]);
        end
    endtask

    task automatic test_random;
        fta_cmd_request32_t rq;
        fta_cmd_request256_t mq0, mqr;
        fta_cmd_response32_t sr;
        logic [31:0] w [8];
        logic [2:0] kind;
        int fe, nr, sn, stl, lat, re;
        bit st, sk, wk;
        for (int n = 0; n < 20; n++) begin
            for (int k = 0; k < 8; k++) w[k] = $urandom;
            rq = '0;
            rq.padr = $urandom;
            rq.sel = 4'($urandom);
            rq.dat = $urandom;
            rq.we = 1'($urandom);
            rq.cmd = 5'($urandom);
            rq.bte = 2'($urandom);
            rq.cti = 3'($urandom);
            rq.tid = 8'($urandom);
            stl = $urandom_range(0, 3);
            lat = $urandom_range(0, 4);
            re = stl + 1 + lat;
            kind = 3'b100 >> $urandom_range(0, 2);
            run_txn(rq, stl, re, kind, pack_words(w), -1, mq0, mqr, sr, fe, nr, sn, st, sk, wk);
            checks++;
            if (mq0.sel !== exp_sel(rq.sel, rq.padr) || mq0.data1 !== exp_data(rq.dat) ||
                mq0.padr !== rq.padr || mq0.tid !== rq.tid || mq0.we !== rq.we ||
                mq0.cmd !== rq.cmd || mq0.bte !== rq.bte || mq0.cti !== rq.cti) begin
                failures++;
                $display("FAIL rand_req n=%0d sel=%h exp=%h padr=%h", n, mq0.sel,
                         exp_sel(rq.sel, rq.padr), mq0.padr);
            end
            checks++;
            if (fe !== re || nr !== 1 || sn !== stl + 1 || !st || !sk || !wk) begin
                failures++;
                $display("FAIL rand_timing n=%0d edge=%0d exp=%0d stb=%0d exp=%0d", n, fe, re,
                         sn, stl + 1);
            end
            checks++;
            if ({sr.ack, sr.err, sr.rty} !== kind || sr.dat !== w[rq.padr[4:2]] ||
                sr.tid !== rq.tid || sr.adr !== (rq.padr ^ 32'h5A5A_0000) ||
                sr.pri !== rq.tid[3:0] || sr.next !== 1'b0) begin
                failures++;
                $display("FAIL rand_resp n=%0d kind=%b exp=%b dat=%h exp=%h", n,
                         {sr.ack, sr.err, sr.rty}, kind, sr.dat, w[rq.padr[4:2]]);
            end
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst_i = 1'b0;
        s_req = '0;
        m_resp = '0;
        test_reset();
        test_read_lane5();
        test_write_byte();
        test_stall();
        test_tid_filter();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fta_bridge32to256.md
# fta_bridge32to256

Upsizing FTA bus bridge that connects a single 32-bit FTA initiator (legacy or DMA master) to the 256-bit system bus. It registers one request at a time, steers 32-bit select and write data into the correct 32-bit lane of the 256-bit word, and tracks the outstanding transaction by `tid`. It then extracts the matching 32-bit lane from the 256-bit response. A watchdog returns a bus error to the initiator if the wide side never responds.

## Interface
- `TIMEOUT`, default 1023: cycles in REQ+WAIT before a forced error completion. Legal range is 1..65535.
- `clk_i` input 1: clock; all logic is on its rising edge.
- `rst_i` input 1: reset, synchronous, active-low.
- `s_req` input `fta_cmd_request32_t`: request from the 32-bit initiator.
- `s_resp` output `fta_cmd_response32_t`: response to the 32-bit initiator.
- `m_req` output `fta_cmd_request256_t`: request to the 256-bit bus.
- `m_resp` input `fta_cmd_response256_t`: response from the 256-bit bus.

## Operation
- **States:**
  - IDLE: waiting for a request.
  - REQ: request presented, waiting for the wide side to stop stalling.
  - WAIT: request taken, waiting for the matching response.
  - RESP: one-cycle completion to the initiator.
- **IDLE → REQ** on `s_req.cyc & s_req.stb`. Capture the following:
  - `cmd`, `bte`, `cti`, `we`, `tid`, `padr` are copied unchanged.
  - `lane = s_req.padr[4:2]`.
  - `m_req.sel = {28'h0, s_req.sel} << {lane,2'b00}`.
  - `m_req.data1 = {8{s_req.dat}}`.
  - The timeout counter is loaded with 0.
- **REQ:**
  - `m_req.cyc = m_req.stb = 1`.
  - REQ → WAIT on the first cycle where `m_resp.stall = 0`.
  - While stalled, all `m_req` fields hold.
- **WAIT:**
  - `m_req.cyc = 1`, `m_req.stb = 0`.
  - A response is accepted only if `(m_resp.ack | m_resp.err | m_resp.rty)` and `m_resp.tid` equals the captured `tid`.
  - Responses with a non-matching `tid` are ignored.
  - An accepted response may also arrive while in REQ, in the non-stalled cycle; it is then accepted as well (REQ → RESP directly).
- **On accept, the state moves to RESP and `s_resp` is registered as:**
  - `ack`, `err`, `rty`, `tid`, `adr`, `pri` copied from `m_resp`.
  - `dat = m_resp.dat[lane*32 +: 32]`.
  - `next = 0`.
- **RESP:**
  - `s_resp` is valid for exactly this one cycle.
  - `m_req` returns to idle values.
  - RESP → IDLE unconditionally.
- **Timeout:**
  - The counter increments in REQ and WAIT.
  - When it reaches `TIMEOUT` with no accepted response, go to RESP with `s_resp.err = 1`, `ack = rty = 0`, `dat = 0`, `tid` = captured tid.
  - If a response and the timeout occur in the same cycle, the response wins.
- **Idle values of `m_req`:** `cyc`/`stb`/`we` = 0, `sel` = 0, `data1` = 0, `padr` = 32'hFFFFFFFF.
- **`s_resp.stall`** = 1 whenever state ≠ IDLE (decoded from the state register). The initiator holds its request while stalled. Requests are sampled only in IDLE.
- Responses arriving in IDLE or RESP are ignored, including late responses after a timeout.
- Deassertion of `s_req.cyc` mid-transaction does not abort. The wide transaction completes and `s_resp` is still issued.

## Timing
- **Reset (`rst_i = 0` at an edge):**
  - State goes to IDLE.
  - `m_req` takes idle values (`padr` = 32'hFFFFFFFF, all other fields 0).
  - All `s_resp` fields are 0, including `stall`.
  - The counter is cleared.
  - Reset mid-transaction abandons it silently; no `s_resp` is issued.
- **Latency:**
  - Request sampled at edge E0.
  - `m_req.stb` is high from E0 to E1.
  - The earliest response is sampled at E1; `s_resp.ack` is then high from E1 to E2.
  - Minimum 2 cycles from `s_req` to `s_resp`, plus wide-side latency and stall cycles.
- **Throughput:** one transaction per (response latency + 2) cycles. There is no pipelining.
- **Timeout:** `s_resp.err` is asserted in the cycle after the counter equals `TIMEOUT`, i.e. `TIMEOUT+1` cycles after leaving IDLE.

## Test plan
- **Read, lane 5:**
  - Stimulus: `s_req` read, `padr` = 0x0000_1014, `sel` = 4'hF, tid 0x21.
  - Expect `m_req.sel` = 32'h00F0_0000 and `padr` = 0x0000_1014.
  - The slave returns `dat` with word5 = 0xCAFEBABE and tid 0x21.
  - Required: `s_resp.ack` = 1 for one cycle, `dat` = 0xCAFEBABE, `s_resp.stall` high until then.
- **Write, byte lane:**
  - Stimulus: `padr` = 0x0000_0008, `sel` = 4'b0100, `dat` = 0x11223344.
  - Required: `m_req.sel` = 32'h0000_0400, `data1` = 8 copies of 0x11223344, `we` = 1; ack is passed through.
- **Stall:**
  - Stimulus: `m_resp.stall` held high for 5 cycles in REQ.
  - Required: `m_req.stb` stays high and unchanged for 6 cycles, then drops.
  - The response completes normally.
- **Tid filter:**
  - Stimulus: in WAIT, an ack with tid 0x22 (expected 0x21), then an ack with tid 0x21 two cycles later.
  - Required: only the second ack produces `s_resp.ack`, exactly once.
- **Timeout:**
  - Setup: `TIMEOUT` = 8; no response.
  - Required: `s_resp.err` = 1, `dat` = 0 exactly 9 cycles after leaving IDLE.
  - A late ack with the same tid 3 cycles later produces no `s_resp`.
- **Reset:**
  - Stimulus: `rst_i` low for one edge while in WAIT.
  - Required: next cycle `m_req.cyc` = 0, `padr` = 32'hFFFFFFFF, `s_resp.stall` = 0, no ack.
  - A new request is then accepted normally.
